// File: rtl/mod_reduce_seq.sv
// Sequential modular reducer: r = n mod p, q = n / p by restoring shift-subtract,
// one quotient bit per clock, with start/busy/done handshake and divide-by-zero flag.
//
//  state   | meaning
//  S_IDLE  | waiting for start; operands and path are captured on accept
//  S_CALC  | one restoring shift-subtract iteration per cycle, N_W cycles
//  S_WRITE | staged result copied into r/q/err, done rises at this edge
//  S_DONE  | done pulse cycle; start is ignored here
module mod_reduce_seq #(
   parameter int N_W = 64,
   parameter int P_W = 32
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_start,
   input  logic [N_W-1:0] i_n,
   input  logic [P_W-1:0] i_p,
   output logic           o_busy,
   output logic           o_done,
   output logic [P_W-1:0] o_r,
   output logic [N_W-1:0] o_q,
   output logic           o_err
);

   localparam int CW = (N_W > 1) ? $clog2(N_W) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_WRITE, S_DONE} state_t;

   state_t         r_state;
   state_t         w_next;

   logic [N_W-1:0] r_n_sh;
   logic [P_W-1:0] r_p;
   logic [P_W-1:0] r_rem;
   logic [N_W-1:0] r_q_sh;
   logic [CW-1:0]  r_cnt;
   logic           r_err_pend;
   logic [P_W-1:0] r_r;
   logic [N_W-1:0] r_q;
   logic           r_err;

   logic [P_W:0]   w_t;
   logic           w_ge;
   logic [P_W-1:0] w_sub;
   logic           w_p_zero;
   logic           w_small;

   // t is one bit wider than p so a remainder above 2^(P_W-1) cannot overflow the compare
   assign w_t      = {r_rem, r_n_sh[N_W-1]};
   assign w_ge     = (w_t >= {1'b0, r_p});
   assign w_sub    = w_t[P_W-1:0] - r_p;
   assign w_p_zero = (i_p == '0);
   assign w_small  = (i_n < N_W'(i_p));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      o_busy = 1'b0;
      o_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_next = (w_p_zero || w_small) ? S_WRITE : S_CALC;
            end
         end
         S_CALC: begin
            o_busy = 1'b1;
            if (r_cnt == '0) begin
               w_next = S_WRITE;
            end
         end
         S_WRITE: begin
            o_busy = 1'b1;
            w_next = S_DONE;
         end
         S_DONE: begin
            o_done = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_n_sh     <= '0;
         r_p        <= '0;
         r_rem      <= '0;
         r_q_sh     <= '0;
         r_cnt      <= '0;
         r_err_pend <= 1'b0;
         r_r        <= {{(P_W-1){1'b0}}, 1'b1};
         r_q        <= '0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_n_sh <= i_n;
                  r_p    <= i_p;
                  r_cnt  <= CW'(N_W-1);
                  // fast and zero paths pre-stage their result so S_WRITE is path-agnostic
                  if (w_p_zero) begin
                     r_rem      <= '0;
                     r_q_sh     <= '1;
                     r_err_pend <= 1'b1;
                  end else if (w_small) begin
                     r_rem      <= i_n[P_W-1:0];
                     r_q_sh     <= '0;
                     r_err_pend <= 1'b0;
                  end else begin
                     r_rem      <= '0;
                     r_q_sh     <= '0;
                     r_err_pend <= 1'b0;
                  end
               end
            end
            S_CALC: begin
               r_rem  <= w_ge ? w_sub : w_t[P_W-1:0];
               r_q_sh <= {r_q_sh[N_W-2:0], w_ge};
               r_n_sh <= {r_n_sh[N_W-2:0], 1'b0};
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_WRITE: begin
               r_r   <= r_rem;
               r_q   <= r_q_sh;
               r_err <= r_err_pend;
            end
            default: begin
            end
         endcase
      end
   end

   assign o_r   = r_r;
   assign o_q   = r_q;
   assign o_err = r_err;

endmodule

// File: tb/tb_mod_reduce_seq.sv
// Directed and model-checked stimulus for mod_reduce_seq (N_W=64, P_W=32).
module tb_mod_reduce_seq;

   localparam int N_W      = 64;
   localparam int P_W      = 32;
   localparam int LAT_CALC = N_W + 1;

   logic           i_clk   = 1'b0;
   logic           i_rst_n = 1'b0;
   logic           i_start = 1'b0;
   logic [N_W-1:0] i_n     = '0;
   logic [P_W-1:0] i_p     = '0;
   logic           o_busy;
   logic           o_done;
   logic [P_W-1:0] o_r;
   logic [N_W-1:0] o_q;
   logic           o_err;

   int n_cmp = 0;
   int n_bad = 0;

   mod_reduce_seq #(.N_W(N_W), .P_W(P_W)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_start (i_start),
      .i_n     (i_n),
      .i_p     (i_p),
      .o_busy  (o_busy),
      .o_done  (o_done),
      .o_r     (o_r),
      .o_q     (o_q),
      .o_err   (o_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   // Issue one op from IDLE and check result, latency, busy coverage and done width.
   // With inj set, a stray start (n=9, p=4) is pulsed mid-CALC and must be ignored.
   task automatic run_op(input string tag, input logic [63:0] nn, input logic [31:0] pp,
                         input bit inj, input logic [31:0] er, input logic [63:0] eq,
                         input logic ee, input int elat);
      int  lat;
      int  busy_cyc;
      bit  overlap;
      @(negedge i_clk);
      i_n     = nn;
      i_p     = pp;
      i_start = 1'b1;
      @(posedge i_clk);
      #1 i_start = 1'b0;
      lat      = -1;
      busy_cyc = 0;
      overlap  = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge i_clk);
         if (o_done && o_busy) overlap = 1'b1;
         if (o_done) begin
            lat = k;
            break;
         end
         if (o_busy) busy_cyc++;
         if (inj && k == 10) begin
            i_start = 1'b1;
            i_n     = 64'd9;
            i_p     = 32'd4;
         end
         if (inj && k == 11) i_start = 1'b0;
         @(posedge i_clk);
      end
      chk($sformatf("%s.lat", tag), 64'(lat), 64'(elat));
      chk($sformatf("%s.r", tag), 64'(o_r), 64'(er));
      chk($sformatf("%s.q", tag), o_q, eq);
      chk($sformatf("%s.err", tag), 64'(o_err), 64'(ee));
      chk($sformatf("%s.busy_cyc", tag), 64'(busy_cyc), 64'(elat));
      chk($sformatf("%s.overlap", tag), 64'(overlap), 64'd0);
      @(negedge i_clk);
      chk($sformatf("%s.done_width", tag), 64'(o_done), 64'd0);
      chk($sformatf("%s.r_hold", tag), 64'(o_r), 64'(er));
   endtask

   task automatic wait_done(input int budget, output bit seen);
      seen = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge i_clk);
         if (o_done) begin
            seen = 1'b1;
            break;
         end
         @(posedge i_clk);
      end
   endtask

   initial begin
      bit          seen;
      logic [63:0] rn;
      logic [31:0] rp;
      logic [63:0] eq;
      logic [31:0] er;

      #12;
      chk("rst.busy", 64'(o_busy), 64'd0);
      chk("rst.done", 64'(o_done), 64'd0);
      chk("rst.r", 64'(o_r), 64'd1);
      chk("rst.q", o_q, 64'd0);
      chk("rst.err", 64'(o_err), 64'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      run_op("t1", 64'd1000, 32'd7, 1'b0, 32'd6, 64'd142, 1'b0, LAT_CALC);
      run_op("t2_fast", 64'd5, 32'd23, 1'b0, 32'd5, 64'd0, 1'b0, 1);
      run_op("t3_wide", 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
             32'd0, 64'h0000_0001_0000_0001, 1'b0, LAT_CALC);
      run_op("t4_p0", 64'd77, 32'd0, 1'b0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1);
      run_op("t4_after", 64'd10, 32'd3, 1'b0, 32'd1, 64'd3, 1'b0, LAT_CALC);
      run_op("eq_np", 64'd23, 32'd23, 1'b0, 32'd0, 64'd1, 1'b0, LAT_CALC);
      run_op("n_pm1", 64'd22, 32'd23, 1'b0, 32'd22, 64'd0, 1'b0, 1);
      run_op("p1", 64'h8000_0000_0000_0001, 32'd1, 1'b0, 32'd0, 64'h8000_0000_0000_0001, 1'b0, LAT_CALC);
      run_op("p_top", 64'hFFFF_FFFF_FFFF_FFFF, 32'h8000_0000, 1'b0,
             32'h7FFF_FFFF, 64'h0000_0001_FFFF_FFFF, 1'b0, LAT_CALC);
      run_op("t5_inj", 64'd1000, 32'd7, 1'b1, 32'd6, 64'd142, 1'b0, LAT_CALC);

      // asynchronous reset 20 iterations into an op
      @(negedge i_clk);
      i_n     = 64'd1000;
      i_p     = 32'd7;
      i_start = 1'b1;
      @(posedge i_clk);
      #1 i_start = 1'b0;
      repeat (20) @(posedge i_clk);
      #2 i_rst_n = 1'b0;
      #1;
      chk("t6.busy", 64'(o_busy), 64'd0);
      chk("t6.done", 64'(o_done), 64'd0);
      chk("t6.r", 64'(o_r), 64'd1);
      chk("t6.q", o_q, 64'd0);
      chk("t6.err", 64'(o_err), 64'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      wait_done(80, seen);
      chk("t6.no_done", 64'(seen), 64'd0);
      run_op("t6_next", 64'd100, 32'd9, 1'b0, 32'd1, 64'd11, 1'b0, LAT_CALC);

      // back-to-back: start held high across two operations
      @(negedge i_clk);
      i_n     = 64'd1000;
      i_p     = 32'd7;
      i_start = 1'b1;
      wait_done(100, seen);
      chk("b2b.first_seen", 64'(seen), 64'd1);
      chk("b2b.first_r", 64'(o_r), 64'd6);
      chk("b2b.first_q", o_q, 64'd142);
      i_n = 64'd10;
      i_p = 32'd3;
      @(posedge i_clk);
      wait_done(100, seen);
      i_start = 1'b0;
      chk("b2b.second_seen", 64'(seen), 64'd1);
      chk("b2b.second_r", 64'(o_r), 64'd1);
      chk("b2b.second_q", o_q, 64'd3);
      @(negedge i_clk);
      @(negedge i_clk);
      chk("b2b.idle", 64'(o_busy), 64'd0);

      // model-checked vectors
      for (int v = 0; v < 150; v++) begin
         rn = {$urandom, $urandom} >> $urandom_range(0, 40);
         rp = $urandom >> $urandom_range(0, 31);
         if (v % 17 == 0) rp = 32'd0;
         if (rp == 32'd0) begin
            run_op($sformatf("rnd%0d", v), rn, rp, 1'b0, 32'd0, '1, 1'b1, 1);
         end else begin
            eq = rn / 64'(rp);
            er = 32'(rn % 64'(rp));
            run_op($sformatf("rnd%0d", v), rn, rp, 1'b0, er, eq, 1'b0,
                   (rn < 64'(rp)) ? 1 : LAT_CALC);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
